// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and aluop. Optional J support via MC_JUMP_EN.
package mips_decls_p;
    typedef logic [5:0] opcode_t;
    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_J     = 6'b000010;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;
endpackage

module mc_controller
    import mips_decls_p::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  mips_decls_p::opcode_t   op,
    input  logic                    zero,
    output logic                    pcen,
    output logic                    memwrite,
    output logic                    iord,
    output logic                    irwrite,
    output logic                    regwrite,
    output logic                    regdst,
    output logic                    memtoreg,
    output logic                    alusrca,
    output logic [1:0]              alusrcb,
    output logic [1:0]              pcsrc,
    output logic [1:0]              aluop,
    output logic                    illegal_op,
    output logic [3:0]              state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    state_t state_reg;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= FETCH;
        end else begin
            case (state_reg)
                FETCH:   state_reg <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_reg <= MEMADR;
                        OP_RTYPE:     state_reg <= RTYPEEX;
                        OP_BEQ:       state_reg <= BEQEX;
                        OP_ADDI:      state_reg <= ADDIEX;
`ifdef MC_JUMP_EN
                        OP_J:         state_reg <= JEX;
`endif
                        default:      state_reg <= FETCH;
                    endcase
                end
                MEMADR:  state_reg <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   state_reg <= MEMWB;
                RTYPEEX: state_reg <= RTYPEWB;
                ADDIEX:  state_reg <= ADDIWB;
                // Terminal states and any unused encoding fall back to FETCH
                default: state_reg <= FETCH;
            endcase
        end
    end

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        case (state_reg)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB:  regwrite = 1'b1;
`ifdef MC_JUMP_EN
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        illegal_op = 1'b0;
        if (state_reg == DECODE) begin
            case (op)
                OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: illegal_op = 1'b0;
`ifdef MC_JUMP_EN
                OP_J:    illegal_op = 1'b0;
`endif
                default: illegal_op = 1'b1;
            endcase
        end
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_reg;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class state by state
// and compares the full output word against hand-written constants.
module tb_mc_controller;
    import mips_decls_p::*;

    logic        clk;
    logic        reset_n;
    opcode_t     op;
    logic        zero;
    logic        pcen, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0]  alusrcb, pcsrc, aluop;
    logic        illegal_op;
    logic [3:0]  state;

    int checks = 0;
    int errors = 0;

    mc_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: state[18:15] | pcen memwrite iord irwrite regwrite regdst memtoreg alusrca
    //              | alusrcb[6:5] | pcsrc[4:3] | aluop[2:1] | illegal_op[0]
    localparam logic [18:0] E_FETCH   = {4'd0,  8'b1001_0000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] E_DEC     = {4'd1,  8'b0000_0000, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] E_DEC_ILL = {4'd1,  8'b0000_0000, 2'b11, 2'b00, 2'b00, 1'b1};
    localparam logic [18:0] E_MEMADR  = {4'd2,  8'b0000_0001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] E_MEMRD   = {4'd3,  8'b0010_0000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] E_MEMWB   = {4'd4,  8'b0000_1010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] E_MEMWR   = {4'd5,  8'b0110_0000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] E_RTEX    = {4'd6,  8'b0000_0001, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [18:0] E_RTWB    = {4'd7,  8'b0000_1100, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] E_BEQ_T   = {4'd8,  8'b1000_0001, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [18:0] E_BEQ_N   = {4'd8,  8'b0000_0001, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [18:0] E_ADEX    = {4'd9,  8'b0000_0001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] E_ADWB    = {4'd10, 8'b0000_1000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] E_JEX     = {4'd11, 8'b1000_0000, 2'b00, 2'b10, 2'b00, 1'b0};

    function automatic logic [18:0] observed();
        return {state, pcen, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, aluop, illegal_op};
    endfunction

    task automatic check(input string tag, input logic [18:0] exp);
        logic [18:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
        $display("check %-14s observed=%05h expected=%05h", tag, obs, exp);
    endtask

    // Called at a falling edge: drive inputs, compare, then move to the next falling edge.
    task automatic step(input string tag, input opcode_t o, input logic z, input logic [18:0] exp);
        op   = o;
        zero = z;
        #1;
        check(tag, exp);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        op      = OP_RTYPE;
        zero    = 1'b0;
        #2;
        check("reset_held", E_FETCH);
        @(posedge clk);
        #1;
        check("reset_edge", E_FETCH);
        @(negedge clk);
        reset_n = 1'b1;

        // RTYPE aborted by an asynchronous reset pulse inside RTYPEEX
        step("rst_fetch",  OP_RTYPE, 1'b0, E_FETCH);
        step("rst_dec",    OP_RTYPE, 1'b0, E_DEC);
        #1;
        check("rst_rtex", E_RTEX);
        reset_n = 1'b0;
        #1;
        check("rst_async", E_FETCH);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        step("post_dec",   OP_RTYPE, 1'b0, E_DEC);
        step("post_rtex",  OP_LW,    1'b0, E_RTEX);
        step("post_rtwb",  OP_LW,    1'b0, E_RTWB);

        // LW
        step("lw_fetch",   OP_LW, 1'b0, E_FETCH);
        step("lw_dec",     OP_LW, 1'b0, E_DEC);
        step("lw_memadr",  OP_LW, 1'b0, E_MEMADR);
        step("lw_memrd",   OP_SW, 1'b1, E_MEMRD);
        step("lw_memwb",   OP_SW, 1'b1, E_MEMWB);

        // SW
        step("sw_fetch",   OP_SW, 1'b0, E_FETCH);
        step("sw_dec",     OP_SW, 1'b0, E_DEC);
        step("sw_memadr",  OP_SW, 1'b0, E_MEMADR);
        step("sw_memwr",   OP_LW, 1'b1, E_MEMWR);

        // RTYPE
        step("rt_fetch",   OP_RTYPE, 1'b0, E_FETCH);
        step("rt_dec",     OP_RTYPE, 1'b0, E_DEC);
        step("rt_ex",      OP_BEQ,   1'b1, E_RTEX);
        step("rt_wb",      OP_BEQ,   1'b1, E_RTWB);

        // BEQ taken then not taken
        step("beqt_fetch", OP_BEQ, 1'b0, E_FETCH);
        step("beqt_dec",   OP_BEQ, 1'b0, E_DEC);
        step("beqt_ex",    OP_BEQ, 1'b1, E_BEQ_T);
        step("beqn_fetch", OP_BEQ, 1'b1, E_FETCH);
        step("beqn_dec",   OP_BEQ, 1'b1, E_DEC);
        step("beqn_ex",    OP_BEQ, 1'b0, E_BEQ_N);

        // ADDI
        step("addi_fetch", OP_ADDI, 1'b0, E_FETCH);
        step("addi_dec",   OP_ADDI, 1'b0, E_DEC);
        step("addi_ex",    OP_LW,   1'b0, E_ADEX);
        step("addi_wb",    OP_LW,   1'b0, E_ADWB);

        // J
        step("j_fetch",    OP_J, 1'b0, E_FETCH);
`ifdef MC_JUMP_EN
        step("j_dec",      OP_J, 1'b0, E_DEC);
        step("j_ex",       OP_J, 1'b0, E_JEX);
`else
        step("j_dec_ill",  OP_J, 1'b0, E_DEC_ILL);
`endif

        // Unrecognised opcode
        step("ill_fetch",  6'b111111, 1'b0, E_FETCH);
        step("ill_dec",    6'b111111, 1'b0, E_DEC_ILL);
        step("ill_back",   6'b111111, 1'b0, E_FETCH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
